// File: rtl/list_fetch_arbiter_pkg.sv
// Shared types and constants for the list fetch arbiter.
// Imported by the interface, the top and the round-robin sub-module.
package list_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2
   } fetch_state_t;

   localparam int CMD_LEN_W  = 8;
   localparam int DBW_DEF    = 256;
   localparam int BEAT_BYTES = DBW_DEF / 8;

   function automatic int LIST_IDX_W(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/list_fetch_arbiter_if.sv
// Bus bundle between the arbiter, its DMA reader and the list caches.
// master = arbiter side, slave = environment side.
interface list_fetch_arbiter_if
   import list_pkg::*;
#(
   parameter int N   = 4,
   parameter int DBW = 256,
   parameter int AW  = 32
);
   localparam int IW = LIST_IDX_W(N);

   logic                 CFG_WE;
   logic [IW-1:0]        CFG_IDX;
   logic [AW-1:0]        CFG_ADDR;
   logic [AW-1:0]        CMD_ADDR;
   logic [CMD_LEN_W-1:0] CMD_LEN;
   logic                 CMD_VALID;
   logic                 CMD_READY;
   logic [DBW-1:0]       S_TDATA;
   logic                 S_TVALID;
   logic                 S_TREADY;
   logic                 S_TLAST;
   logic [N-1:0]         REQ;
   logic [DBW-1:0]       M_TDATA;
   logic [N-1:0]         M_TVALID;
   logic [3:0]           M_TDEST;
   logic                 ERR;

   modport master (
      input  CFG_WE, CFG_IDX, CFG_ADDR,
      input  CMD_READY,
      input  S_TDATA, S_TVALID, S_TLAST,
      input  REQ,
      output CMD_ADDR, CMD_LEN, CMD_VALID,
      output S_TREADY,
      output M_TDATA, M_TVALID, M_TDEST,
      output ERR
   );

   modport slave (
      output CFG_WE, CFG_IDX, CFG_ADDR,
      output CMD_READY,
      output S_TDATA, S_TVALID, S_TLAST,
      output REQ,
      input  CMD_ADDR, CMD_LEN, CMD_VALID,
      input  S_TREADY,
      input  M_TDATA, M_TVALID, M_TDEST,
      input  ERR
   );

endinterface

// File: rtl/list_fetch_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request strictly after last.
// Search starts at last+1 and wraps modulo N.
module rr_arbiter
   import list_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = LIST_IDX_W(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic [N-1:0]  gnt_oh_o,
   output logic [IW-1:0] gnt_idx_o,
   output logic          any_o
);

   always_comb begin
      any_o     = 1'b0;
      gnt_idx_o = '0;
      for (int k = 1; k <= N; k++) begin
         if (!any_o && req_i[(int'(last_i) + k) % N]) begin
            any_o     = 1'b1;
            gnt_idx_o = IW'((int'(last_i) + k) % N);
         end
      end
   end

   assign gnt_oh_o = any_o ? (N'(1) << gnt_idx_o) : '0;

endmodule

// File: rtl/list_fetch_arbiter.sv
// Round-robin fetch scheduler sharing one DMA read channel among N list caches.
// Issues fixed-length bursts from per-list pointers and steers the return stream.
module list_fetch_arbiter
   import list_pkg::*;
#(
   parameter int N     = 4,
   parameter int DBW   = 256,
   parameter int AW    = 32,
   parameter int BURST = 2
) (
   input  logic                 ACLK,
   input  logic                 ARESETn,
   list_fetch_arbiter_if.master bus
);

   localparam int                   IW   = LIST_IDX_W(N);
   localparam logic [AW-1:0]        STEP = AW'(BURST * (DBW / 8));
   localparam logic [CMD_LEN_W-1:0] LEN  = CMD_LEN_W'(BURST);

   fetch_state_t         state_q, state_d;
   logic [IW-1:0]        gnt_q, gnt_d;
   logic [N-1:0]         oh_q, oh_d;
   logic [IW-1:0]        last_q, last_d;
   logic [CMD_LEN_W-1:0] beats_q, beats_d;
   logic                 err_q, err_d;

   logic [AW-1:0]        addr_q [N];
   logic [N-1:0]         en_q;

   logic [N-1:0]         elig;
   logic [N-1:0]         arb_oh;
   logic [IW-1:0]        arb_idx;
   logic                 arb_any;
   logic                 in_cmd, in_data;
   logic                 cmd_hs, dat_hs;
   logic                 cnt_end, fin;

   assign elig = bus.REQ & en_q;

   rr_arbiter #(
      .N  (N),
      .IW (IW)
   ) u_rr (
      .req_i     (elig),
      .last_i    (last_q),
      .gnt_oh_o  (arb_oh),
      .gnt_idx_o (arb_idx),
      .any_o     (arb_any)
   );

   assign in_cmd  = (state_q == CMD);
   assign in_data = (state_q == DATA);
   assign cmd_hs  = in_cmd & bus.CMD_READY;
   assign dat_hs  = in_data & bus.S_TVALID;
   assign cnt_end = (beats_q + CMD_LEN_W'(1)) == LEN;
   // A burst ends on whichever comes first: TLAST or the beat count.
   assign fin     = dat_hs & (bus.S_TLAST | cnt_end);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      oh_d    = oh_q;
      last_d  = last_q;
      beats_d = beats_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (arb_any) begin
               gnt_d   = arb_idx;
               oh_d    = arb_oh;
               state_d = CMD;
            end
         end
         CMD: begin
            if (cmd_hs) begin
               beats_d = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (dat_hs) begin
               beats_d = beats_q + CMD_LEN_W'(1);
            end
            if (fin) begin
               last_d  = gnt_q;
               state_d = IDLE;
               if (bus.S_TLAST != cnt_end) err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         oh_q    <= '0;
         last_q  <= IW'(N - 1);
         beats_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         oh_q    <= oh_d;
         last_q  <= last_d;
         beats_q <= beats_d;
         err_q   <= err_d;
      end
   end

   // Config write is last so it overrides a same-cycle pointer advance.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         for (int i = 0; i < N; i++) addr_q[i] <= '0;
         en_q <= '0;
      end else begin
         if (cmd_hs) addr_q[gnt_q] <= addr_q[gnt_q] + STEP;
         if (bus.CFG_WE) begin
            addr_q[bus.CFG_IDX] <= bus.CFG_ADDR;
            en_q[bus.CFG_IDX]   <= 1'b1;
         end
      end
   end

   assign bus.CMD_VALID = in_cmd;
   assign bus.CMD_ADDR  = in_cmd ? addr_q[gnt_q] : '0;
   assign bus.CMD_LEN   = LEN;
   assign bus.S_TREADY  = in_data;
   assign bus.M_TDATA   = in_data ? bus.S_TDATA : '0;
   assign bus.M_TVALID  = dat_hs ? oh_q : '0;
   assign bus.M_TDEST   = in_data ? 4'(gnt_q) : 4'd0;
   assign bus.ERR       = err_q;

endmodule

// File: tb/tb_list_fetch_arbiter.sv
// Randomized self-checking bench for list_fetch_arbiter.
// Reference model tracks pointers, enables, last grant and error flag.
module tb_list_fetch_arbiter;

   localparam int N     = 4;
   localparam int DBW   = 256;
   localparam int AW    = 32;
   localparam int BURST = 2;
   localparam int STEP  = BURST * DBW / 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   list_fetch_arbiter_if #(.N(N), .DBW(DBW), .AW(AW)) bus ();

   list_fetch_arbiter #(
      .N     (N),
      .DBW   (DBW),
      .AW    (AW),
      .BURST (BURST)
   ) dut (
      .ACLK    (clk),
      .ARESETn (rst_n),
      .bus     (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0] addr_m [N];
   logic [3:0]  en_m;
   int          last_m;
   bit          err_m;

   function automatic int pick(input logic [3:0] r);
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (last_m + k) % N;
         if (r[j] && en_m[j]) return j;
      end
      return -1;
   endfunction

   function automatic logic [255:0] rnd_data();
      logic [255:0] d;
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [31:0] rnd_addr();
      logic [31:0] a;
      a = $urandom;
      return a & 32'hFFFF_FFE0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) addr_m[i] = '0;
      en_m   = '0;
      last_m = N - 1;
      err_m  = 1'b0;
   endtask

   task automatic idle_inputs();
      bus.CFG_WE    = 1'b0;
      bus.CFG_IDX   = '0;
      bus.CFG_ADDR  = '0;
      bus.CMD_READY = 1'b0;
      bus.S_TDATA   = '0;
      bus.S_TVALID  = 1'b0;
      bus.S_TLAST   = 1'b0;
      bus.REQ       = '0;
   endtask

   task automatic cfg(input int idx, input logic [31:0] a);
      @(negedge clk);
      bus.CFG_WE   = 1'b1;
      bus.CFG_IDX  = idx[1:0];
      bus.CFG_ADDR = a;
      @(negedge clk);
      bus.CFG_WE   = 1'b0;
      addr_m[idx]  = a;
      en_m[idx]    = 1'b1;
   endtask

   // One grant-command-data sequence, checked against the model.
   task automatic run_burst(input int stall, input int tlast_at,
                            input bit collide, input logic [31:0] cval,
                            input bit drop_req);
      int           idx, waitc, b;
      bit           done, sv, tl;
      logic [255:0] d;
      logic [31:0]  exp_a;
      logic [3:0]   ev;
      idx = pick(bus.REQ);
      total++;
      if (idx < 0) begin
         bad++;
         $display("FAIL pick: req=%b en=%b no eligible", bus.REQ, en_m);
         return;
      end
      waitc = 0;
      done  = 1'b0;
      while (!done && waitc < 20) begin
         @(negedge clk);
         #1;
         waitc++;
         done = bus.CMD_VALID;
      end
      total++;
      if (!done || waitc != 1) begin
         bad++;
         $display("FAIL cmd_wait: cycles=%0d required=1", waitc);
      end
      if (!done) return;
      exp_a = addr_m[idx];
      total++;
      if (bus.CMD_ADDR !== exp_a || bus.CMD_LEN !== 8'(BURST)) begin
         bad++;
         $display("FAIL cmd: addr=%h len=%0d required addr=%h len=%0d idx=%0d",
                  bus.CMD_ADDR, bus.CMD_LEN, exp_a, BURST, idx);
      end
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         bus.S_TVALID = 1'b1;
         bus.S_TDATA  = rnd_data();
         #1;
         total++;
         if (bus.CMD_VALID !== 1'b1 || bus.CMD_ADDR !== exp_a ||
             bus.S_TREADY !== 1'b0 || bus.M_TVALID !== 4'd0) begin
            bad++;
            $display("FAIL cmd_stall: v=%b addr=%h rdy=%b mv=%b required 1 %h 0 0",
                     bus.CMD_VALID, bus.CMD_ADDR, bus.S_TREADY, bus.M_TVALID, exp_a);
         end
      end
      bus.S_TVALID  = 1'b0;
      bus.CMD_READY = 1'b1;
      if (collide) begin
         bus.CFG_WE   = 1'b1;
         bus.CFG_IDX  = idx[1:0];
         bus.CFG_ADDR = cval;
      end
      if (drop_req) bus.REQ = '0;
      @(negedge clk);
      bus.CMD_READY = 1'b0;
      bus.CFG_WE    = 1'b0;
      addr_m[idx] = collide ? cval : exp_a + STEP;
      b     = 0;
      done  = 1'b0;
      waitc = 0;
      while (!done && waitc < 50) begin
         sv = ($urandom_range(0, 3) != 0);
         tl = sv && (b == tlast_at);
         d  = rnd_data();
         bus.S_TVALID = sv;
         bus.S_TLAST  = tl;
         bus.S_TDATA  = d;
         #1;
         ev = sv ? 4'(1 << idx) : 4'd0;
         total++;
         if (bus.S_TREADY !== 1'b1 || bus.M_TVALID !== ev ||
             bus.M_TDEST !== 4'(idx) || bus.M_TDATA !== d) begin
            bad++;
            $display("FAIL beat: rdy=%b mv=%b dest=%0d data_ok=%b required 1 %b %0d 1",
                     bus.S_TREADY, bus.M_TVALID, bus.M_TDEST,
                     bus.M_TDATA === d, ev, idx);
         end
         if (sv) begin
            b++;
            if (tl || b == BURST) begin
               done   = 1'b1;
               last_m = idx;
               if (tl != (b == BURST)) err_m = 1'b1;
            end
         end
         waitc++;
         @(negedge clk);
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL data_timeout: beats=%0d required end", b);
      end
      bus.S_TVALID = 1'b0;
      bus.S_TLAST  = 1'b0;
      #1;
      total++;
      if (bus.S_TREADY !== 1'b0 || bus.M_TVALID !== 4'd0 ||
          bus.CMD_VALID !== 1'b0 || bus.ERR !== err_m) begin
         bad++;
         $display("FAIL burst_end: rdy=%b mv=%b cv=%b err=%b required 0 0 0 %b",
                  bus.S_TREADY, bus.M_TVALID, bus.CMD_VALID, bus.ERR, err_m);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      total++;
      if (bus.CMD_VALID !== 1'b0 || bus.CMD_ADDR !== 32'd0 ||
          bus.CMD_LEN !== 8'(BURST) || bus.S_TREADY !== 1'b0) begin
         bad++;
         $display("FAIL %s_cmd: v=%b addr=%h len=%0d rdy=%b required 0 0 %0d 0",
                  tag, bus.CMD_VALID, bus.CMD_ADDR, bus.CMD_LEN, bus.S_TREADY, BURST);
      end
      total++;
      if (bus.M_TVALID !== 4'd0 || bus.M_TDATA !== 256'd0 ||
          bus.M_TDEST !== 4'd0 || bus.ERR !== 1'b0) begin
         bad++;
         $display("FAIL %s_out: mv=%b data0=%b dest=%0d err=%b required 0 1 0 0",
                  tag, bus.M_TVALID, bus.M_TDATA === 256'd0, bus.M_TDEST, bus.ERR);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      model_reset();
      rst_n = 1'b0;
      #2;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n   = 1'b1;
      bus.REQ = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         total++;
         if (bus.CMD_VALID !== 1'b0) begin
            bad++;
            $display("FAIL no_en_cmd: cmd_valid=%b required 0", bus.CMD_VALID);
         end
      end
      bus.REQ = '0;
   endtask

   task automatic test_single();
      cfg(1, 32'h1000);
      bus.REQ = 4'b0010;
      run_burst(0, BURST - 1, 1'b0, 32'd0, 1'b0);
      run_burst(0, BURST - 1, 1'b0, 32'd0, 1'b0);
      bus.REQ = '0;
      total++;
      if (addr_m[1] !== 32'h1080) begin
         bad++;
         $display("FAIL single_ptr: model=%h required 1080", addr_m[1]);
      end
   endtask

   task automatic test_cmd_stall();
      cfg(2, rnd_addr());
      bus.REQ = 4'b0100;
      run_burst(5, BURST - 1, 1'b0, 32'd0, 1'b0);
      bus.REQ = '0;
   endtask

   task automatic test_collide();
      cfg(0, 32'h0000_0100);
      bus.REQ = 4'b0001;
      run_burst(0, BURST - 1, 1'b1, 32'h2000, 1'b0);
      run_burst(0, BURST - 1, 1'b0, 32'd0, 1'b1);
      bus.REQ = '0;
   endtask

   task automatic test_tlast_early();
      bus.REQ = 4'b0010;
      run_burst(0, 0, 1'b0, 32'd0, 1'b0);
      bus.REQ = '0;
      total++;
      if (bus.ERR !== 1'b1) begin
         bad++;
         $display("FAIL err_sticky: err=%b required 1", bus.ERR);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < N; i++) if (!en_m[i]) cfg(i, rnd_addr());
      for (int t = 0; t < 14; t++) begin
         bus.REQ = 4'($urandom_range(1, 15));
         run_burst($urandom_range(0, 3), BURST - 1,
                   ($urandom_range(0, 4) == 0), rnd_addr(),
                   ($urandom_range(0, 2) == 0));
      end
      bus.REQ = '0;
   endtask

   task automatic test_reset_mid();
      int waitc;
      bus.REQ = 4'b1000;
      waitc = 0;
      while (bus.CMD_VALID !== 1'b1 && waitc < 20) begin
         @(negedge clk);
         #1;
         waitc++;
      end
      total++;
      if (bus.CMD_VALID !== 1'b1) begin
         bad++;
         $display("FAIL mid_cmd: cmd_valid=%b required 1", bus.CMD_VALID);
      end
      bus.CMD_READY = 1'b1;
      @(negedge clk);
      bus.CMD_READY = 1'b0;
      bus.S_TVALID  = 1'b1;
      bus.S_TDATA   = rnd_data();
      #1;
      total++;
      if (bus.M_TVALID !== 4'b1000) begin
         bad++;
         $display("FAIL mid_data: mv=%b required 1000", bus.M_TVALID);
      end
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      bus.S_TVALID = 1'b0;
      bus.REQ      = 4'b1111;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         total++;
         if (bus.CMD_VALID !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_cmd: cmd_valid=%b required 0", bus.CMD_VALID);
         end
      end
      bus.REQ = '0;
   endtask

   task automatic test_round_robin();
      int order [5];
      for (int i = 0; i < N; i++) cfg(i, 32'h4000 * (i + 1));
      bus.REQ = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         order[t] = pick(bus.REQ);
         run_burst($urandom_range(0, 2), BURST - 1, 1'b0, 32'd0, 1'b0);
      end
      bus.REQ = '0;
      for (int t = 0; t < 5; t++) begin
         total++;
         if (order[t] != t % N) begin
            bad++;
            $display("FAIL rr_order: slot=%0d got=%0d required=%0d", t, order[t], t % N);
         end
      end
      total++;
      if (addr_m[0] !== 32'h4080 || addr_m[3] !== 32'h10040) begin
         bad++;
         $display("FAIL rr_ptr: a0=%h a3=%h required 4080 10040", addr_m[0], addr_m[3]);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_cmd_stall();
      test_collide();
      test_tlast_early();
      test_random();
      test_reset_mid();
      test_round_robin();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
